pc_redirect_unit: RTL and testbench

- Sequential consumer of the branch/jump select and flush requests produced by the pipeline's branch/jump signal logic.
- Owns the program counter and the instruction-memory fetch request handshake.
- Applies redirects (branch, JALR, JAL), stalls and flushes to the PC and to the IF/ID and ID/EX valid/kill controls.
- Sits between the EX-stage branch/jump resolution and the IF stage.

---
 rtl/pc_redirect_unit_pkg.sv | 34 +++
 rtl/pc_redirect_unit_if.sv | 51 +++++
 rtl/pc_redirect_unit_target_select.sv | 43 ++++
 rtl/pc_redirect_unit.sv | 176 +++++++++++++++++
 tb/tb_pc_redirect_unit.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/pc_redirect_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_redirect_unit_pkg
//  Description : Shared types and constants for the PC redirect unit:
//                redirect-select encodings, FSM state type, datapath width,
//                PC increment and a misalignment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_redirect_unit_pkg;

  localparam int XLEN = 32;

  // Sequential fetch stride (one 32-bit instruction)
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  // redirect_sel encodings
  localparam logic [1:0] SEL_BRANCH = 2'b00;
  localparam logic [1:0] SEL_JALR   = 2'b01;
  localparam logic [1:0] SEL_JAL    = 2'b10;
  localparam logic [1:0] SEL_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  // Instruction fetch addresses must be word aligned
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_redirect_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_redirect_unit_if
//  Description : Bundle between EX-stage branch/jump resolution, the
//                instruction-memory fetch handshake and the pipeline
//                valid/kill controls.
//                master : environment (drives requests, imem_ready)
//                slave  : pc_redirect_unit (drives PC, imem_valid, controls)
//  Ports       : redirect_sel, flush_IF_ID, flush_ID_EX, stall,
//                branch_target, jalr_target, jal_target, imem_ready (to unit)
//                PC, imem_valid, IF_ID_valid, ID_EX_kill, misaligned_trap,
//                redirect_count (from unit)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_redirect_unit_if #(
  parameter int CNT_W = 16
);
  import pc_redirect_unit_pkg::*;

  logic [1:0]      redirect_sel;
  logic            flush_IF_ID;
  logic            flush_ID_EX;
  logic            stall;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] jal_target;
  logic            imem_ready;

  logic [XLEN-1:0] PC;
  logic            imem_valid;
  logic            IF_ID_valid;
  logic            ID_EX_kill;
  logic            misaligned_trap;
  logic [CNT_W-1:0] redirect_count;

  modport master (
    output redirect_sel, flush_IF_ID, flush_ID_EX, stall,
           branch_target, jalr_target, jal_target, imem_ready,
    input  PC, imem_valid, IF_ID_valid, ID_EX_kill, misaligned_trap,
           redirect_count
  );

  modport slave (
    input  redirect_sel, flush_IF_ID, flush_ID_EX, stall,
           branch_target, jalr_target, jal_target, imem_ready,
    output PC, imem_valid, IF_ID_valid, ID_EX_kill, misaligned_trap,
           redirect_count
  );

endinterface
`default_nettype wire

// File: rtl/pc_redirect_unit_target_select.sv
`default_nettype none
// ============================================================================
//  Module      : pc_target_select
//  Description : Combinational redirect-target mux. Masks bit 0 of the JALR
//                target and flags word-misaligned targets.
//  Ports       : redirect_sel, branch_target, jalr_target, jal_target (in)
//                redirect, target, misaligned (out)
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_target_select
  import pc_redirect_unit_pkg::*;
(
  input  logic [1:0]      redirect_sel,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jalr_target,
  input  logic [XLEN-1:0] jal_target,
  output logic            redirect,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  // JALR clears the LSB of rs1+imm, so that bit never reaches the PC
  logic w_unused_jalr_lsb;
  assign w_unused_jalr_lsb = jalr_target[0];

  always_comb begin
    redirect = 1'b1;
    target   = branch_target;
    case (redirect_sel)
      SEL_BRANCH: target = branch_target;
      SEL_JALR:   target = {jalr_target[XLEN-1:1], 1'b0};
      SEL_JAL:    target = jal_target;
      default: begin
        redirect = 1'b0;
        target   = branch_target;
      end
    endcase
  end

  assign misaligned = redirect & is_misaligned(target);

endmodule
`default_nettype wire

// File: rtl/pc_redirect_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_redirect_unit
//  Description : Owns the program counter and the instruction fetch request.
//                Applies branch/JALR/JAL redirects (with misaligned-target
//                trap), stalls and flushes; holds a redirect in a pending
//                register while the fetch handshake is back-pressured.
//  Ports       : clk      - clock, rising edge
//                reset_n  - asynchronous active-low reset
//                bus      - pc_redirect_unit_if.slave (requests in, PC,
//                           imem_valid, IF_ID_valid, ID_EX_kill,
//                           misaligned_trap, redirect_count out)
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              CNT_W        = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  pc_redirect_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Registered state
  state_t           r_state;
  logic [XLEN-1:0]  r_pc;
  logic             r_if_id_valid;
  logic             r_id_ex_kill;
  logic             r_trap;
  logic [CNT_W-1:0] r_count;
  logic [XLEN-1:0]  r_pend_target;
  logic             r_pend_trap;

  // Next-state values
  state_t           w_state_nxt;
  logic [XLEN-1:0]  w_pc_nxt;
  logic             w_if_id_valid_nxt;
  logic             w_id_ex_kill_nxt;
  logic             w_trap_nxt;
  logic             w_count_inc;
  logic [XLEN-1:0]  w_pend_target_nxt;
  logic             w_pend_trap_nxt;
  logic             w_imem_valid;

  // Target mux outputs
  logic             w_redirect;
  logic [XLEN-1:0]  w_sel_target;
  logic             w_sel_misaligned;
  logic [XLEN-1:0]  w_eff_target;
  logic [XLEN-1:0]  w_pend_cand;
  logic             w_pend_cand_trap;

  pc_target_select u_target_select (
    .redirect_sel  (bus.redirect_sel),
    .branch_target (bus.branch_target),
    .jalr_target   (bus.jalr_target),
    .jal_target    (bus.jal_target),
    .redirect      (w_redirect),
    .target        (w_sel_target),
    .misaligned    (w_sel_misaligned)
  );

  // A misaligned target is replaced by the trap vector up front, so the
  // pending register always holds the address that will actually be fetched.
  assign w_eff_target = w_sel_misaligned ? TRAP_VECTOR : w_sel_target;

  // In PENDING the youngest redirect wins over the stored one
  assign w_pend_cand      = w_redirect ? w_eff_target     : r_pend_target;
  assign w_pend_cand_trap = w_redirect ? w_sel_misaligned : r_pend_trap;

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_if_id_valid_nxt = r_if_id_valid;
    w_id_ex_kill_nxt  = bus.flush_ID_EX | bus.stall;
    w_trap_nxt        = 1'b0;
    w_count_inc       = 1'b0;
    w_pend_target_nxt = r_pend_target;
    w_pend_trap_nxt   = r_pend_trap;
    w_imem_valid      = 1'b0;

    case (r_state)
      ST_BOOT: begin
        w_state_nxt       = ST_FETCH;
        w_if_id_valid_nxt = 1'b0;
        w_id_ex_kill_nxt  = 1'b0;
      end

      ST_FETCH: begin
        w_imem_valid = 1'b1;
        if (w_redirect) begin
          w_if_id_valid_nxt = 1'b0;
          if (bus.imem_ready) begin
            w_pc_nxt    = w_eff_target;
            w_trap_nxt  = w_sel_misaligned;
            w_count_inc = 1'b1;
          end else begin
            // PC must stay stable until the outstanding request is taken
            w_pend_target_nxt = w_eff_target;
            w_pend_trap_nxt   = w_sel_misaligned;
            w_state_nxt       = ST_PENDING;
          end
        end else begin
          // A flush without a redirect still advances the PC normally
          if (bus.imem_ready && !bus.stall) begin
            w_pc_nxt = r_pc + PC_INC;
          end
          if (bus.flush_IF_ID) begin
            w_if_id_valid_nxt = 1'b0;
          end else if (bus.stall) begin
            w_if_id_valid_nxt = r_if_id_valid;
          end else begin
            w_if_id_valid_nxt = bus.imem_ready;
          end
        end
      end

      ST_PENDING: begin
        w_imem_valid      = 1'b1;
        w_if_id_valid_nxt = 1'b0;
        if (bus.imem_ready) begin
          w_pc_nxt    = w_pend_cand;
          w_trap_nxt  = w_pend_cand_trap;
          w_count_inc = 1'b1;
          w_state_nxt = ST_FETCH;
        end else begin
          w_pend_target_nxt = w_pend_cand;
          w_pend_trap_nxt   = w_pend_cand_trap;
        end
      end

      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_VECTOR;
      r_if_id_valid <= 1'b0;
      r_id_ex_kill  <= 1'b0;
      r_trap        <= 1'b0;
      r_count       <= '0;
      r_pend_target <= '0;
      r_pend_trap   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_if_id_valid <= w_if_id_valid_nxt;
      r_id_ex_kill  <= w_id_ex_kill_nxt;
      r_trap        <= w_trap_nxt;
      r_pend_target <= w_pend_target_nxt;
      r_pend_trap   <= w_pend_trap_nxt;
      if (w_count_inc && (r_count != C_CNT_MAX)) begin
        r_count <= r_count + C_CNT_ONE;
      end
    end
  end

  assign bus.PC              = r_pc;
  assign bus.imem_valid      = w_imem_valid;
  assign bus.IF_ID_valid     = r_if_id_valid;
  assign bus.ID_EX_kill      = r_id_ex_kill;
  assign bus.misaligned_trap = r_trap;
  assign bus.redirect_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_redirect_unit
//  Description : Self-checking bench for pc_redirect_unit: a table of
//                directed single-cycle vectors plus hand-written sequences
//                for reset during PENDING and counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_redirect_unit;
  import pc_redirect_unit_pkg::*;

  localparam int CNT_W = 16;

  logic clk;
  logic reset_n;

  int n_checks = 0;
  int n_errors = 0;

  pc_redirect_unit_if #(.CNT_W(CNT_W)) bus ();

  pc_redirect_unit #(
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .CNT_W        (CNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       sel;
    logic [31:0]      tgt;
    logic             rdy;
    logic             stl;
    logic             fl_ifid;
    logic             fl_idex;
    logic [31:0]      e_pc;
    logic             e_valid;
    logic             e_ifid;
    logic             e_kill;
    logic             e_trap;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Targets not selected get distinct aligned junk so a wrong mux leg shows up
  task automatic drive(input logic [1:0] sel, input logic [31:0] tgt, input logic rdy,
                       input logic stl, input logic fi, input logic fe);
    bus.redirect_sel  = sel;
    bus.branch_target = (sel == SEL_BRANCH) ? tgt : 32'hBAD0_0000;
    bus.jalr_target   = (sel == SEL_JALR)   ? tgt : 32'hBAD1_0000;
    bus.jal_target    = (sel == SEL_JAL)    ? tgt : 32'hBAD2_0000;
    bus.imem_ready    = rdy;
    bus.stall         = stl;
    bus.flush_IF_ID   = fi;
    bus.flush_ID_EX   = fe;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [1:0] sel, input logic [31:0] tgt, input logic rdy,
                     input logic stl, input logic fi, input logic fe,
                     input logic [31:0] pc, input logic v, input logic ifid,
                     input logic kill, input logic trap, input logic [CNT_W-1:0] cnt);
    vecs.push_back(vec_t'{sel, tgt, rdy, stl, fi, fe, pc, v, ifid, kill, trap, cnt});
  endtask

  initial begin
    //   sel         tgt            rdy  stl  fi   fe     PC             v  ifid kill trap cnt
    add(SEL_SEQ,    32'h0,         1'b1,1'b0,1'b0,1'b0,  32'h0000_0000, 1, 0, 0, 0, 16'd0); // BOOT->FETCH
    add(SEL_SEQ,    32'h0,         1'b1,1'b0,1'b0,1'b0,  32'h0000_0004, 1, 1, 0, 0, 16'd0);
    add(SEL_SEQ,    32'h0,         1'b1,1'b0,1'b0,1'b0,  32'h0000_0008, 1, 1, 0, 0, 16'd0);
    add(SEL_SEQ,    32'h0,         1'b1,1'b0,1'b0,1'b0,  32'h0000_000C, 1, 1, 0, 0, 16'd0);
    add(SEL_SEQ,    32'h0,         1'b1,1'b0,1'b0,1'b0,  32'h0000_0010, 1, 1, 0, 0, 16'd0);
    add(SEL_BRANCH, 32'h0000_0040, 1'b1,1'b0,1'b0,1'b0,  32'h0000_0040, 1, 0, 0, 0, 16'd1);
    add(SEL_SEQ,    32'h0,         1'b1,1'b0,1'b0,1'b0,  32'h0000_0044, 1, 1, 0, 0, 16'd1);
    add(SEL_JALR,   32'h0000_0081, 1'b1,1'b0,1'b0,1'b0,  32'h0000_0080, 1, 0, 0, 0, 16'd2);
    add(SEL_JAL,    32'h0000_0042, 1'b1,1'b0,1'b0,1'b0,  32'h0000_0100, 1, 0, 0, 1, 16'd3);
    add(SEL_SEQ,    32'h0,         1'b1,1'b0,1'b0,1'b0,  32'h0000_0104, 1, 1, 0, 0, 16'd3);
    add(SEL_JAL,    32'h0000_001C, 1'b1,1'b0,1'b0,1'b0,  32'h0000_001C, 1, 0, 0, 0, 16'd4);
    add(SEL_SEQ,    32'h0,         1'b1,1'b0,1'b0,1'b0,  32'h0000_0020, 1, 1, 0, 0, 16'd4);
    add(SEL_SEQ,    32'h0,         1'b1,1'b1,1'b0,1'b0,  32'h0000_0020, 1, 1, 1, 0, 16'd4); // stall
    add(SEL_SEQ,    32'h0,         1'b1,1'b1,1'b0,1'b0,  32'h0000_0020, 1, 1, 1, 0, 16'd4); // stall
    add(SEL_SEQ,    32'h0,         1'b1,1'b0,1'b0,1'b0,  32'h0000_0024, 1, 1, 0, 0, 16'd4);
    add(SEL_SEQ,    32'h0,         1'b1,1'b0,1'b0,1'b1,  32'h0000_0028, 1, 1, 1, 0, 16'd4); // flush ID/EX
    add(SEL_SEQ,    32'h0,         1'b1,1'b0,1'b1,1'b0,  32'h0000_002C, 1, 0, 0, 0, 16'd4); // flush IF/ID, seq
    add(SEL_SEQ,    32'h0,         1'b0,1'b0,1'b0,1'b0,  32'h0000_002C, 1, 0, 0, 0, 16'd4); // not ready
    add(SEL_SEQ,    32'h0,         1'b1,1'b0,1'b0,1'b0,  32'h0000_0030, 1, 1, 0, 0, 16'd4);
    add(SEL_JAL,    32'hFFFF_FFFC, 1'b1,1'b0,1'b0,1'b0,  32'hFFFF_FFFC, 1, 0, 0, 0, 16'd5);
    add(SEL_SEQ,    32'h0,         1'b1,1'b0,1'b0,1'b0,  32'h0000_0000, 1, 1, 0, 0, 16'd5); // wrap
    add(SEL_SEQ,    32'h0,         1'b1,1'b0,1'b0,1'b0,  32'h0000_0004, 1, 1, 0, 0, 16'd5);
    add(SEL_JAL,    32'h0000_0200, 1'b0,1'b0,1'b0,1'b0,  32'h0000_0004, 1, 0, 0, 0, 16'd5); // -> PENDING
    add(SEL_BRANCH, 32'h0000_0300, 1'b0,1'b0,1'b0,1'b0,  32'h0000_0004, 1, 0, 0, 0, 16'd5); // overwrite
    add(SEL_SEQ,    32'h0,         1'b1,1'b0,1'b0,1'b0,  32'h0000_0300, 1, 0, 0, 0, 16'd6); // handshake
    add(SEL_SEQ,    32'h0,         1'b1,1'b0,1'b0,1'b0,  32'h0000_0304, 1, 1, 0, 0, 16'd6);
    add(SEL_BRANCH, 32'h0000_0302, 1'b0,1'b0,1'b0,1'b0,  32'h0000_0304, 1, 0, 0, 0, 16'd6); // misaligned, pending
    add(SEL_SEQ,    32'h0,         1'b1,1'b1,1'b0,1'b0,  32'h0000_0100, 1, 0, 1, 1, 16'd7); // stall ignored
    add(SEL_SEQ,    32'h0,         1'b1,1'b0,1'b0,1'b0,  32'h0000_0104, 1, 1, 0, 0, 16'd7);

    // Reset state
    reset_n = 1'b0;
    drive(SEL_SEQ, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("reset PC",    bus.PC, 32'h0);
    check("reset valid", {31'b0, bus.imem_valid}, 32'h0);
    check("reset ifid",  {31'b0, bus.IF_ID_valid}, 32'h0);
    check("reset kill",  {31'b0, bus.ID_EX_kill}, 32'h0);
    check("reset trap",  {31'b0, bus.misaligned_trap}, 32'h0);
    check("reset count", {16'b0, bus.redirect_count}, 32'h0);

    reset_n = 1'b1;
    #1;
    check("boot valid", {31'b0, bus.imem_valid}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].sel, vecs[i].tgt, vecs[i].rdy, vecs[i].stl, vecs[i].fl_ifid, vecs[i].fl_idex);
      tick();
      check($sformatf("v%0d PC", i),    bus.PC, vecs[i].e_pc);
      check($sformatf("v%0d valid", i), {31'b0, bus.imem_valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("v%0d ifid", i),  {31'b0, bus.IF_ID_valid}, {31'b0, vecs[i].e_ifid});
      check($sformatf("v%0d kill", i),  {31'b0, bus.ID_EX_kill}, {31'b0, vecs[i].e_kill});
      check($sformatf("v%0d trap", i),  {31'b0, bus.misaligned_trap}, {31'b0, vecs[i].e_trap});
      check($sformatf("v%0d count", i), {16'b0, bus.redirect_count}, {16'b0, vecs[i].e_cnt});
    end

    // Reset while a redirect is pending: PC returns at once, pending is lost
    drive(SEL_JAL, 32'h0000_0500, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("pend hold PC", bus.PC, 32'h0000_0104);
    reset_n = 1'b0;
    #1;
    check("async rst PC",    bus.PC, 32'h0);
    check("async rst valid", {31'b0, bus.imem_valid}, 32'h0);
    check("async rst count", {16'b0, bus.redirect_count}, 32'h0);
    drive(SEL_SEQ, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post rst PC0", bus.PC, 32'h0);
    tick();
    check("post rst PC4", bus.PC, 32'h0000_0004);
    check("post rst count", {16'b0, bus.redirect_count}, 32'h0);

    // Saturation of the redirect counter
    drive(SEL_BRANCH, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk);
    end
    #1;
    check("sat count fffe", {16'b0, bus.redirect_count}, 32'h0000_FFFE);
    tick();
    check("sat count ffff", {16'b0, bus.redirect_count}, 32'h0000_FFFF);
    tick();
    tick();
    tick();
    check("sat count hold", {16'b0, bus.redirect_count}, 32'h0000_FFFF);
    check("sat PC", bus.PC, 32'h0000_0040);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
